// File: rtl/pc_update_unit_pkg.sv
// Shared definitions for the PC update stage.
// Holds the branch_type and exc_code encodings, the exception FSM state
// encoding and the default reset/vector constants. The branch encodings
// are also used by the control unit through branch_cond_eval.
package pc_update_unit_pkg;

    // branch_type encodings
    localparam logic [1:0] BR_BEQ = 2'b00;
    localparam logic [1:0] BR_BNE = 2'b01;
    localparam logic [1:0] BR_BLE = 2'b10;
    localparam logic [1:0] BR_BGT = 2'b11;

    // exc_code encodings; 2'b11 is reserved and handled as EXC_OPCODE
    localparam logic [1:0] EXC_OPCODE = 2'b00;
    localparam logic [1:0] EXC_OVF    = 2'b01;
    localparam logic [1:0] EXC_DIV0   = 2'b10;
    localparam logic [1:0] EXC_RSVD   = 2'b11;

    // Exception-entry sequence states
    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_EXC_FETCH  = 2'b01,
        ST_EXC_COMMIT = 2'b10
    } exc_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC     = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VEC_BASE = 32'd253;

    // Folds the reserved cause onto invalid-opcode.
    function automatic logic [1:0] normalize_exc_code(input logic [1:0] code);
        return (code == EXC_RSVD) ? EXC_OPCODE : code;
    endfunction

endpackage

// File: rtl/pc_update_unit_branch_cond_eval.sv
// branch_cond_eval: combinational branch-taken decision.
// Ports:
//   branch_type in  [1:0] beq / bne / ble / bgt
//   alu_zero    in        ALU zero flag
//   alu_lt      in        ALU less-than flag
//   take        out       branch condition holds
module branch_cond_eval
    import pc_update_unit_pkg::*;
(
    input  logic [1:0] branch_type,
    input  logic       alu_zero,
    input  logic       alu_lt,
    output logic       take
);

    always_comb begin
        take = 1'b0;
        case (branch_type)
            BR_BEQ:  take = alu_zero;
            BR_BNE:  take = !alu_zero;
            BR_BLE:  take = alu_zero | alu_lt;
            BR_BGT:  take = !alu_zero & !alu_lt;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_update_unit.sv
// pc_update_unit: program-counter update stage.
// Owns PC and EPC, applies unconditional/branch PC writes taken from the
// PC-source mux, and runs the exception entry: save EPC, fetch the
// handler byte from memory, load PC with it.
// Ports:
//   clk, reset (async, active-low)
//   pc_next[31:0], pc_write, pc_write_cond, branch_type[1:0],
//   alu_zero, alu_lt              - normal PC update inputs
//   exc_req, exc_code[1:0]        - exception request and cause
//   mem_req, mem_addr[31:0]       - handler-byte read request (decoded)
//   mem_ack, mem_rdata[7:0]       - handler-byte read response
//   pc, epc                       - registered PC / exception PC
//   exc_busy                      - exception sequence in progress
//   pc_written                    - PC was updated at the previous edge
module pc_update_unit
    import pc_update_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter logic [31:0] EXC_VEC_BASE = DEFAULT_EXC_VEC_BASE
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_next,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic [1:0]  branch_type,
    input  logic        alu_zero,
    input  logic        alu_lt,
    input  logic        exc_req,
    input  logic [1:0]  exc_code,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [31:0] pc,
    output logic [31:0] epc,
    output logic        exc_busy,
    output logic        pc_written
);

    exc_state_t  state_q, state_d;
    logic [1:0]  code_q, code_d;
    logic [7:0]  hbyte_q, hbyte_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic        busy_q, busy_d;
    logic        written_q, written_d;

    logic take;
    logic do_write;

    branch_cond_eval u_branch_cond_eval (
        .branch_type (branch_type),
        .alu_zero    (alu_zero),
        .alu_lt      (alu_lt),
        .take        (take)
    );

    assign do_write = pc_write | (pc_write_cond & take);

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        hbyte_d   = hbyte_q;
        pc_d      = pc_q;
        epc_d     = epc_q;
        written_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Exception wins over a simultaneous PC write.
                if (exc_req) begin
                    code_d  = normalize_exc_code(exc_code);
                    epc_d   = pc_q - 32'd4;
                    state_d = ST_EXC_FETCH;
                end else if (do_write) begin
                    pc_d      = pc_next;
                    written_d = 1'b1;
                end
            end
            ST_EXC_FETCH: begin
                // No timeout: wait for the ack as long as it takes.
                if (mem_ack) begin
                    hbyte_d = mem_rdata;
                    state_d = ST_EXC_COMMIT;
                end
            end
            ST_EXC_COMMIT: begin
                pc_d      = {24'b0, hbyte_q};
                written_d = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Registered busy flag tracks the next state so it lines up with it.
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            code_q    <= 2'b00;
            hbyte_q   <= 8'h00;
            pc_q      <= RESET_PC;
            epc_q     <= 32'h0000_0000;
            busy_q    <= 1'b0;
            written_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            hbyte_q   <= hbyte_d;
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            busy_q    <= busy_d;
            written_q <= written_d;
        end
    end

    // Request/address decoded from registered state so they drop the
    // instant reset is applied and stay stable through the fetch.
    assign mem_req  = (state_q == ST_EXC_FETCH);
    assign mem_addr = mem_req ? (EXC_VEC_BASE + {30'b0, code_q}) : 32'h0000_0000;

    assign pc         = pc_q;
    assign epc        = epc_q;
    assign exc_busy   = busy_q;
    assign pc_written = written_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// Self-checking bench for pc_update_unit: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_pc_update_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] VEC_BASE = 32'd253;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_next;
    logic        pc_write, pc_write_cond;
    logic [1:0]  branch_type;
    logic        alu_zero, alu_lt;
    logic        exc_req;
    logic [1:0]  exc_code;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [31:0] pc, epc;
    logic        exc_busy, pc_written;

    int checks   = 0;
    int failures = 0;
    int cycle_no = 0;

    // Behavioural model: an exception "episode" is active from acceptance
    // until the cycle after the handler byte arrives.
    logic [31:0] m_pc, m_epc;
    logic        m_written;
    logic        m_in_exc;
    int          m_ack_cycle;   // -1 until the handler byte has arrived
    logic [1:0]  m_cause;
    logic [7:0]  m_handler;

    always #5 clk = ~clk;

    pc_update_unit #(.RESET_PC(RESET_PC), .EXC_VEC_BASE(VEC_BASE)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_next       (pc_next),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_type   (branch_type),
        .alu_zero      (alu_zero),
        .alu_lt        (alu_lt),
        .exc_req       (exc_req),
        .exc_code      (exc_code),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .pc            (pc),
        .epc           (epc),
        .exc_busy      (exc_busy),
        .pc_written    (pc_written)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cycle_no);
        end
    endtask

    function automatic logic branch_taken(input logic [1:0] bt, input logic z, input logic lt);
        // Compare-result view: beq ==, bne !=, ble <=, bgt >.
        case (bt)
            2'd0:    return z;
            2'd1:    return !z;
            2'd2:    return z || lt;
            default: return !(z || lt);
        endcase
    endfunction

    task automatic model_reset();
        m_pc        = RESET_PC;
        m_epc       = 32'h0;
        m_written   = 1'b0;
        m_in_exc    = 1'b0;
        m_ack_cycle = -1;
        m_cause     = 2'd0;
        m_handler   = 8'h00;
    endtask

    task automatic model_edge();
        logic in_exc_before;
        in_exc_before = m_in_exc;
        m_written = 1'b0;
        if (!in_exc_before) begin
            if (exc_req) begin
                m_in_exc    = 1'b1;
                m_ack_cycle = -1;
                m_cause     = (exc_code == 2'd3) ? 2'd0 : exc_code;
                m_epc       = m_pc - 32'd4;
            end else if (pc_write || (pc_write_cond && branch_taken(branch_type, alu_zero, alu_lt))) begin
                m_pc      = pc_next;
                m_written = 1'b1;
            end
        end else if (m_ack_cycle < 0) begin
            if (mem_ack) begin
                m_ack_cycle = cycle_no;
                m_handler   = mem_rdata;
            end
        end else begin
            m_pc      = {24'b0, m_handler};
            m_written = 1'b1;
            m_in_exc  = 1'b0;
        end
    endtask

    task automatic compare_all(input string tag);
        logic exp_req;
        exp_req = m_in_exc && (m_ack_cycle < 0);
        check_val({tag, "_pc"},       pc,                 m_pc);
        check_val({tag, "_epc"},      epc,                m_epc);
        check_val({tag, "_written"},  {31'b0, pc_written}, {31'b0, m_written});
        check_val({tag, "_busy"},     {31'b0, exc_busy},   {31'b0, m_in_exc});
        check_val({tag, "_mem_req"},  {31'b0, mem_req},    {31'b0, exp_req});
        check_val({tag, "_mem_addr"}, mem_addr, exp_req ? VEC_BASE + 32'(m_cause) : 32'h0);
    endtask

    // One clock: inputs are already driven; model advances at the edge and
    // outputs are sampled 1 time unit later.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        cycle_no++;
        #1;
        compare_all(tag);
        $display("cyc=%0d %s pc=%h epc=%h req=%b addr=%0d busy=%b wr=%b",
                 cycle_no, tag, pc, epc, mem_req, mem_addr, exc_busy, pc_written);
    endtask

    task automatic idle_inputs();
        pc_next = 32'h0; pc_write = 0; pc_write_cond = 0; branch_type = 0;
        alu_zero = 0; alu_lt = 0; exc_req = 0; exc_code = 0;
        mem_ack = 0; mem_rdata = 8'h00;
    endtask

    task automatic load_pc(input logic [31:0] v);
        idle_inputs();
        pc_write = 1; pc_next = v;
        step("load");
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 0;
        model_reset();
        #12;
        compare_all("reset");
        reset = 1;
        #2;

        // 1: unconditional write
        pc_write = 1; pc_next = 32'h4;
        step("t1_write");
        idle_inputs();
        step("t1_after");
        check_val("t1_pc_const", pc, 32'h4);

        // 2: branch table at pc=0x40
        for (int bt = 0; bt < 4; bt++) begin
            for (int f = 0; f < 3; f++) begin
                load_pc(32'h40);
                pc_write_cond = 1; pc_next = 32'h80;
                branch_type = 2'(bt);
                alu_zero = (f == 2); alu_lt = (f == 1);
                step("t2_branch");
                idle_inputs();
            end
        end

        // 3: exception with wait cycles
        load_pc(32'h108);
        exc_req = 1; exc_code = 2'b01;
        step("t3_req");
        idle_inputs();
        check_val("t3_epc_const", epc, 32'h104);
        for (int w = 0; w < 3; w++) begin
            step("t3_wait");
            check_val("t3_addr_const", mem_addr, 32'd254);
        end
        mem_ack = 1; mem_rdata = 8'h7C;
        step("t3_ack");
        idle_inputs();
        step("t3_commit");
        check_val("t3_pc_const", pc, 32'h7C);
        check_val("t3_busy_low", {31'b0, exc_busy}, 32'h0);

        // 4: exception beats simultaneous write
        exc_req = 1; exc_code = 2'b10; pc_write = 1; pc_next = 32'hAAAA_AAAA;
        step("t4_req");
        idle_inputs();
        check_val("t4_epc_const", epc, 32'h78);

        // 5: nested exception and writes while busy are ignored
        exc_req = 1; exc_code = 2'b00; pc_write = 1; pc_next = 32'h1234_5678;
        step("t5_busy_req");
        step("t5_busy_req2");
        idle_inputs();
        mem_ack = 1; mem_rdata = 8'h33;
        step("t5_ack");
        exc_req = 1; pc_write = 1; pc_next = 32'h5555_0000; mem_ack = 0;
        step("t5_commit");
        idle_inputs();
        step("t5_idle");

        // 6: reset in the middle of a fetch, then a stray ack
        load_pc(32'h200);
        exc_req = 1; exc_code = 2'b11;
        step("t6_req");
        idle_inputs();
        step("t6_wait");
        #2 reset = 0;
        model_reset();
        #1;
        compare_all("t6_async_reset");
        #2 reset = 1;
        mem_ack = 1; mem_rdata = 8'hEE;
        step("t6_stray_ack");
        idle_inputs();
        exc_req = 1;
        step("t6_pc0_exc");
        idle_inputs();
        check_val("t6_epc_wrap", epc, 32'hFFFF_FFFC);
        mem_ack = 1; mem_rdata = 8'h10;
        step("t6_ack");
        idle_inputs();
        step("t6_commit");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            pc_next       = $urandom;
            pc_write      = ($urandom_range(0, 5) == 0);
            pc_write_cond = ($urandom_range(0, 2) == 0);
            branch_type   = 2'($urandom_range(0, 3));
            alu_zero      = 1'($urandom_range(0, 1));
            alu_lt        = 1'($urandom_range(0, 1));
            exc_req       = ($urandom_range(0, 9) == 0);
            exc_code      = 2'($urandom_range(0, 3));
            mem_ack       = ($urandom_range(0, 2) == 0);
            mem_rdata     = 8'($urandom);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
